irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt controller that shares the single CPU interrupt line among the three timer/counter `OUT` lines and up to five further device requests. It edge-detects each source into a pending register, applies a software mask and fixed priority, and raises `IRQ`. A vectored `IACK`/EOI handshake sequences each interrupt. It sits on the same `ADD`/`STB`/`WE` register bus as the timer block, between the peripherals and the CPU control unit.

## Interface
- `NSRC`, default 8: number of sources, 1..16; source 0 has the highest priority. Timer `OUT[2:0]` connects to `SRC[2:0]`.
- `CLK`  in  1  rising-edge clock
- `RST`  in  1  reset, asynchronous and active-low
- `SRC`  in  NSRC  interrupt sources, level inputs, edge-sensitive
- `ADD`  in  4 (`[5:2]`)  register word address
- `STB`  in  1  bus strobe; writes require `STB & WE`
- `WE`  in  1  write enable
- `DAT_I`  in  32  write data
- `DAT_O`  out  32  read data, combinational from `ADD`
- `IRQ`  out  1  registered interrupt request to the CPU
- `IACK`  in  1  one-cycle acknowledge from the CPU
- `VEC`  out  4  ID of the source being requested or serviced, registered

## Operation
- Register map by `ADD`:
  - 0 PEND: read returns pending bits; write-1-to-clear.
  - 1 MASK: read/write; 1 enables the source.
  - 2 CAUSE: read only; bit 31 is in-service, bits [3:0] equal `VEC`.
  - 3 EOI: write of any value ends service.
  - 4 SWSET: write ORs `DAT_I` into PEND.
  - Other addresses read 0 and ignore writes.
  - Bits at or above `NSRC` read 0.
- Edge detect:
  - `SRC_d` registers `SRC` every cycle.
  - A rise (`SRC & ~SRC_d`) sets the PEND bit. PEND is independent of MASK.
- Priority: the winner is the lowest index with `PEND & MASK` = 1.
- FSM states are IDLE, REQ and SVC.
  - IDLE: if `PEND & MASK` ≠ 0, latch the winner into `VEC`, then go to REQ.
  - REQ: `IRQ` = 1.
    - On `IACK`, clear `PEND[VEC]`, set CAUSE[31] and go to SVC.
    - If `PEND[VEC]` or `MASK[VEC]` drops before `IACK`, go to IDLE. This is a withdraw: `IRQ` falls and there is no service.
    - A higher-priority arrival in REQ does not change `VEC`.
  - SVC: `IRQ` = 0. On an EOI write, clear CAUSE[31] and go to IDLE. `IACK` is ignored in SVC and IDLE.
  - No nesting: new edges in REQ and SVC only accumulate in PEND.
- Simultaneous events on one PEND bit in the same cycle:
  - A set from an edge or SWSET beats a W1C clear.
  - An `IACK` clear also loses to a new edge, so the bit stays pending for the next round.
- Reset values:
  - PEND, MASK and `SRC_d` = 0.
  - State = IDLE.
  - `IRQ` = 0, `VEC` = 0, CAUSE = 0.
  - `DAT_O` follows the reset register values.
- Reset asserted mid-operation returns everything to the reset values immediately, without waiting for a clock. Edges in progress are lost.

## Timing
- A `SRC` rise sampled at edge k sets PEND after edge k. The FSM enters REQ at edge k+1, so `IRQ` is high after k+1: a two-cycle source-to-IRQ latency when the source is already unmasked.
- `IACK` high at edge m: `IRQ` low and CAUSE[31] = 1 after edge m.
- EOI write at edge n: IDLE after n. If another request is pending, `IRQ` rises again after n+1 (one idle cycle minimum).
- Withdraw takes effect on the edge where the FSM samples the dropped bit.
- Register writes take effect at the write edge. `DAT_O` reflects the new value in the following cycle.
- A held-high source produces one PEND set only. It must fall and rise again to re-request.

## Test plan
- Reset, `MASK`=0x01, `SRC[0]` rises:
  - `IRQ`=1 two cycles later, `VEC`=0.
  - `IACK`: `IRQ`=0, CAUSE=0x80000000, PEND=0.
  - EOI write: CAUSE=0.
- `MASK`=0xFF, `SRC[5]` and `SRC[2]` rise together:
  - `VEC`=2 first.
  - After `IACK` and EOI, `IRQ` reasserts with `VEC`=5.
- Source rises with `MASK`=0:
  - PEND=0x08 and `IRQ` stays 0.
  - Write `MASK`=0x08: `IRQ`=1 within 2 cycles.
- In REQ with `VEC`=3, write PEND=0x08 (W1C): `IRQ` drops, no service, state returns to IDLE.
- In the same cycle, `SRC[1]` rises, a W1C clear of bit 1 is written and `IACK` arrives for `VEC`=1: PEND[1] remains 1.
- Drop `RST` while in SVC: `IRQ`=0, `VEC`=0, PEND=MASK=CAUSE=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-detecting, masked, fixed-priority interrupt controller with IACK/EOI sequencing
module irq_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NSRC-1:0] SRC,
    input  logic [3:0]      ADD,
    input  logic            STB,
    input  logic            WE,
    input  logic [31:0]     DAT_I,
    output logic [31:0]     DAT_O,
    output logic            IRQ,
    input  logic            IACK,
    output logic [3:0]      VEC
);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    localparam logic [3:0] A_PEND  = 4'd0;
    localparam logic [3:0] A_MASK  = 4'd1;
    localparam logic [3:0] A_CAUSE = 4'd2;
    localparam logic [3:0] A_EOI   = 4'd3;
    localparam logic [3:0] A_SWSET = 4'd4;

    state_t          state;
    logic [NSRC-1:0] src_d;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pend_nxt;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] req_bits;
    logic [NSRC-1:0] vec_oh;
    logic            in_svc;
    logic            vec_ok;
    logic            ack;
    logic            wr;
    logic [3:0]      win;
    logic            unused_dat;

    assign unused_dat = ^DAT_I[31:NSRC];

    assign wr       = STB & WE;
    assign rise     = SRC & ~src_d;
    assign req_bits = pend & mask;
    assign vec_oh   = NSRC'(1) << VEC;
    assign vec_ok   = |(req_bits & vec_oh);
    assign ack      = (state == REQ) && IACK && vec_ok;

    // Scan high-to-low so the lowest pending index wins.
    always_comb begin
        win = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_bits[i]) win = 4'(i);
        end
    end

    // Clears are applied first so that edges and SWSET always win a same-cycle race.
    always_comb begin
        pend_nxt = pend;
        if (wr && ADD == A_PEND) pend_nxt = pend_nxt & ~DAT_I[NSRC-1:0];
        if (ack)                 pend_nxt = pend_nxt & ~vec_oh;
        pend_nxt = pend_nxt | rise;
        if (wr && ADD == A_SWSET) pend_nxt = pend_nxt | DAT_I[NSRC-1:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            src_d <= '0;
            pend  <= '0;
            mask  <= '0;
        end else begin
            src_d <= SRC;
            pend  <= pend_nxt;
            if (wr && ADD == A_MASK) mask <= DAT_I[NSRC-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            IRQ    <= 1'b0;
            VEC    <= 4'd0;
            in_svc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_bits) begin
                        VEC   <= win;
                        IRQ   <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    // A withdrawn request takes precedence over a late acknowledge.
                    if (!vec_ok) begin
                        IRQ   <= 1'b0;
                        state <= IDLE;
                    end else if (IACK) begin
                        IRQ    <= 1'b0;
                        in_svc <= 1'b1;
                        state  <= SVC;
                    end
                end
                SVC: begin
                    if (wr && ADD == A_EOI) begin
                        in_svc <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    IRQ   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        DAT_O = 32'd0;
        case (ADD)
            A_PEND:  DAT_O = 32'(pend);
            A_MASK:  DAT_O = 32'(mask);
            A_CAUSE: DAT_O = {in_svc, 27'd0, VEC};
            default: DAT_O = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed and randomized checks of irq_ctrl against a reference model
module tb_irq_ctrl;

    localparam int N = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [N-1:0]  SRC = '0;
    logic [3:0]    ADD = '0;
    logic          STB = 1'b0;
    logic          WE = 1'b0;
    logic [31:0]   DAT_I = '0;
    logic [31:0]   DAT_O;
    logic          IRQ;
    logic          IACK = 1'b0;
    logic [3:0]    VEC;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending/enable sets plus a "who is being asked / served" record.
    logic [N-1:0] m_pend, m_mask, m_prev;
    bit           m_asking, m_serving;
    int           m_vec;

    irq_ctrl #(.NSRC(N)) dut (
        .CLK(CLK), .RST(RST), .SRC(SRC), .ADD(ADD), .STB(STB), .WE(WE),
        .DAT_I(DAT_I), .DAT_O(DAT_O), .IRQ(IRQ), .IACK(IACK), .VEC(VEC)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0;
        m_asking = 0; m_serving = 0; m_vec = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:    return 32'(m_pend);
            4'd1:    return 32'(m_mask);
            4'd2:    return {m_serving, 27'd0, 4'(m_vec)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        bit           wr = STB && WE;
        bit           granted = 0;
        logic [N-1:0] np = m_pend;
        bit           live = m_pend[m_vec] && m_mask[m_vec];
        if (m_serving) begin
            if (wr && ADD == 4'd3) m_serving = 0;
        end else if (m_asking) begin
            if (!live) m_asking = 0;
            else if (IACK) begin
                granted = 1; m_asking = 0; m_serving = 1;
            end
        end else if ((m_pend & m_mask) != 0) begin
            for (int i = 0; i < N; i++)
                if (m_pend[i] && m_mask[i]) begin m_vec = i; break; end
            m_asking = 1;
        end
        if (wr && ADD == 4'd0) np &= ~DAT_I[N-1:0];
        if (granted) np[m_vec] = 1'b0;
        for (int i = 0; i < N; i++)
            if (SRC[i] && !m_prev[i]) np[i] = 1'b1;
        if (wr && ADD == 4'd4) np |= DAT_I[N-1:0];
        if (wr && ADD == 4'd1) m_mask = DAT_I[N-1:0];
        m_pend = np;
        m_prev = SRC;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
        STB = 0; WE = 0; IACK = 0;
        chk("irq", 32'(IRQ), 32'(m_asking));
        chk("vec", 32'(VEC), 32'(m_vec));
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        ADD = a; DAT_I = d; STB = 1; WE = 1;
        cycle();
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        ADD = a;
        #1;
        chk(tag, DAT_O, exp);
    endtask

    initial begin
        model_reset();
        #23;
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk("rst_vec", 32'(VEC), 32'd0);
        rd("rst_pend", 4'd0, 32'd0);
        RST = 1;
        cycle();
        rd("rst_mask", 4'd1, 32'd0);
        rd("rst_cause", 4'd2, 32'd0);

        // Single source, full handshake
        wr_reg(4'd1, 32'h01);
        SRC = 8'h01;
        cycle();
        chk("t1_lat", 32'(IRQ), 32'd0);
        cycle();
        chk("t1_irq", 32'(IRQ), 32'd1);
        chk("t1_vec", 32'(VEC), 32'd0);
        IACK = 1;
        cycle();
        chk("t1_ack_irq", 32'(IRQ), 32'd0);
        rd("t1_cause", 4'd2, 32'h8000_0000);
        rd("t1_pend", 4'd0, 32'd0);
        wr_reg(4'd3, 32'd0);
        rd("t1_eoi_cause", 4'd2, 32'd0);
        SRC = '0;
        cycle();

        // Priority between two simultaneous sources
        wr_reg(4'd1, 32'hFF);
        SRC = 8'h24;
        cycle(); cycle();
        chk("t2_vec2", 32'(VEC), 32'd2);
        IACK = 1;
        cycle();
        wr_reg(4'd3, 32'd0);
        cycle();
        chk("t2_irq5", 32'(IRQ), 32'd1);
        chk("t2_vec5", 32'(VEC), 32'd5);
        IACK = 1;
        cycle();
        wr_reg(4'd3, 32'd0);
        SRC = '0;
        cycle();

        // Masked source stays pending, then unmask
        wr_reg(4'd1, 32'h00);
        SRC = 8'h08;
        cycle(); cycle();
        rd("t3_pend", 4'd0, 32'h08);
        chk("t3_noirq", 32'(IRQ), 32'd0);
        wr_reg(4'd1, 32'h08);
        cycle();
        chk("t3_irq", 32'(IRQ), 32'd1);
        chk("t3_vec", 32'(VEC), 32'd3);

        // Withdraw by W1C in REQ
        SRC = '0;
        wr_reg(4'd0, 32'h08);
        cycle();
        chk("t4_withdraw", 32'(IRQ), 32'd0);
        rd("t4_cause", 4'd2, 32'h3);
        rd("t4_pend", 4'd0, 32'd0);

        // Edge beats W1C and IACK clears on the same cycle
        wr_reg(4'd1, 32'h02);
        SRC = 8'h02;
        cycle();
        SRC = '0;
        cycle();
        chk("t5_vec", 32'(VEC), 32'd1);
        SRC = 8'h02; IACK = 1;
        wr_reg(4'd0, 32'h02);
        rd("t5_pend", 4'd0, 32'h02);
        rd("t5_cause", 4'd2, 32'h8000_0001);

        // Asynchronous reset while in service
        #2;
        RST = 0;
        model_reset();
        #1;
        chk("t6_irq", 32'(IRQ), 32'd0);
        chk("t6_vec", 32'(VEC), 32'd0);
        rd("t6_pend", 4'd0, 32'd0);
        rd("t6_mask", 4'd1, 32'd0);
        rd("t6_cause", 4'd2, 32'd0);
        SRC = '0;
        RST = 1;
        cycle();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) SRC[i] = ~SRC[i];
            ADD = 4'($urandom_range(0, 7));
            DAT_I = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                STB = 1; WE = 1;
                if (ADD == 4'd0 || ADD == 4'd4) DAT_I = 32'($urandom_range(0, 3)) << $urandom_range(0, 7);
            end
            if (m_asking ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0)) IACK = 1;
            if (m_serving && $urandom_range(0, 4) == 0) begin
                ADD = 4'd3; STB = 1; WE = 1;
            end
            cycle();
            ADD = 4'($urandom_range(0, 5));
            #1;
            chk("rand_read", DAT_O, model_read(ADD));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
